// File: rtl/ucsbece154b_mem_pkg.sv
// Shared types for the SDRAM block-read path (arbiter, icache, prefetcher).
package ucsbece154b_mem_pkg;

    localparam int unsigned DEF_BLOCK_WORDS = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DRAIN
    } arb_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_PF = 1'b1
    } owner_t;

endpackage

// File: rtl/ucsbece154b_arb_pick.sv
// Demand-priority winner select with a streak limit so a waiting prefetch
// is eventually served.
module ucsbece154b_arb_pick
    import ucsbece154b_mem_pkg::*;
#(
    parameter int unsigned MAX_DEM_STREAK = 3
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   ic_req,
    input  logic   pf_req,
    input  logic   grant,
    output owner_t winner
);

    localparam int unsigned SW = $clog2(MAX_DEM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DEM_STREAK);

    logic [SW-1:0] streak;

    always_comb begin
        winner = OWN_IC;
        if (pf_req && (!ic_req || streak == STREAK_MAX)) begin
            winner = OWN_PF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (grant) begin
            if (winner == OWN_PF || !pf_req) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + SW'(1);
            end
        end
    end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Shares the SDRAM block-read channel between the icache demand port and the
// next-line prefetcher; one burst at a time, routed back to its owner only.
module ucsbece154b_mem_arbiter
    import ucsbece154b_mem_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS    = DEF_BLOCK_WORDS,
    parameter int unsigned MAX_DEM_STREAK = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           icReadRequest,
    input  logic [31:0]                    icReadAddress,
    output logic                           icDataReady,
    input  logic                           pfReadRequest,
    input  logic [31:0]                    pfReadAddress,
    output logic                           pfDataReady,
    output logic [31:0]                    memDataOut,
    output logic [$clog2(BLOCK_WORDS)-1:0] memBlockIdxOut,
    output logic                           memReadRequest,
    output logic [31:0]                    memReadAddress,
    input  logic [31:0]                    memDataIn,
    input  logic                           memDataReady,
    input  logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex,
    output logic                           grantOwner,
    output logic                           busy
);

    localparam int unsigned IW = $clog2(BLOCK_WORDS);
    localparam logic [IW-1:0] LAST_WORD = IW'(BLOCK_WORDS - 1);

    arb_state_t    state;
    owner_t        owner_q;
    owner_t        winner;
    word_t         addr_q;
    logic [IW-1:0] word_cnt;
    logic          orphan;

    logic any_req;
    logic grant;
    logic owner_req;
    logic beat;
    logic deliver;

    assign any_req   = icReadRequest | pfReadRequest;
    assign grant     = (state == IDLE) && any_req;
    assign owner_req = (owner_q == OWN_PF) ? pfReadRequest : icReadRequest;

    // Word 0 arrives in the REQ cycle that sees memDataReady, so it is
    // delivered and counted there; XFER carries the remaining words.
    assign beat    = ((state == REQ) || (state == XFER)) && memDataReady;
    assign deliver = beat && !orphan && owner_req;

    ucsbece154b_arb_pick #(
        .MAX_DEM_STREAK(MAX_DEM_STREAK)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .ic_req(icReadRequest),
        .pf_req(pfReadRequest),
        .grant (grant),
        .winner(winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner_q  <= OWN_IC;
            addr_q   <= '0;
            word_cnt <= '0;
            orphan   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    word_cnt <= '0;
                    if (any_req) begin
                        owner_q <= winner;
                        addr_q  <= (winner == OWN_PF) ? pfReadAddress : icReadAddress;
                        state   <= REQ;
                    end
                end
                REQ, XFER: begin
                    if (!owner_req) begin
                        orphan <= 1'b1;
                    end
                    if (memDataReady) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            word_cnt <= word_cnt + IW'(1);
                            state    <= XFER;
                        end
                    end
                end
                DRAIN: begin
                    if (!memDataReady) begin
                        orphan <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign grantOwner     = owner_q;
    assign memReadRequest = (state == REQ) && !memDataReady;
    assign memReadAddress = addr_q;
    assign memDataOut     = beat ? memDataIn : '0;
    assign memBlockIdxOut = beat ? memBlockIndex : '0;
    assign icDataReady    = deliver && (owner_q == OWN_IC);
    assign pfDataReady    = deliver && (owner_q == OWN_PF);

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for the SDRAM read arbiter: grant order, routing, abandon, reset.
module tb_ucsbece154b_mem_arbiter;
    import ucsbece154b_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        icReadRequest;
    logic [31:0] icReadAddress;
    logic        icDataReady;
    logic        pfReadRequest;
    logic [31:0] pfReadAddress;
    logic        pfDataReady;
    logic [31:0] memDataOut;
    logic [1:0]  memBlockIdxOut;
    logic        memReadRequest;
    logic [31:0] memReadAddress;
    logic [31:0] memDataIn;
    logic        memDataReady;
    logic [1:0]  memBlockIndex;
    logic        grantOwner;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    ucsbece154b_mem_arbiter #(
        .BLOCK_WORDS   (4),
        .MAX_DEM_STREAK(3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .icReadRequest (icReadRequest),
        .icReadAddress (icReadAddress),
        .icDataReady   (icDataReady),
        .pfReadRequest (pfReadRequest),
        .pfReadAddress (pfReadAddress),
        .pfDataReady   (pfDataReady),
        .memDataOut    (memDataOut),
        .memBlockIdxOut(memBlockIdxOut),
        .memReadRequest(memReadRequest),
        .memReadAddress(memReadAddress),
        .memDataIn     (memDataIn),
        .memDataReady  (memDataReady),
        .memBlockIndex (memBlockIndex),
        .grantOwner    (grantOwner),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Entered at a sample point with the DUT in REQ; returns at the DRAIN sample point.
    task automatic txn(input logic own, input logic [31:0] addr, input int unsigned lat,
                       input int unsigned drop_at, input int unsigned raise_ic_at,
                       input logic [31:0] ic_addr);
        chk("req_hi", 32'(memReadRequest), 1);
        chk("req_addr", memReadAddress, addr);
        chk("owner", 32'(grantOwner), 32'(own));
        chk("req_busy", 32'(busy), 1);
        repeat (lat) begin
            @(negedge clk);
            #1;
            chk("req_wait", 32'(memReadRequest), 1);
            chk("rdy_wait", 32'({icDataReady, pfDataReady}), 0);
        end
        for (int unsigned w = 0; w < 4; w++) begin
            @(negedge clk);
            if (w == drop_at) begin
                if (own) pfReadRequest = 1'b0;
                else     icReadRequest = 1'b0;
            end
            if (w == raise_ic_at) begin
                icReadRequest = 1'b1;
                icReadAddress = ic_addr;
            end
            memDataReady  = 1'b1;
            memBlockIndex = w[1:0];
            memDataIn     = 32'hD000_0000 + addr + w;
            #1;
            chk("ic_rdy", 32'(icDataReady), 32'(!own && w < drop_at));
            chk("pf_rdy", 32'(pfDataReady), 32'(own && w < drop_at));
            chk("data", memDataOut, 32'hD000_0000 + addr + w);
            chk("idx", 32'(memBlockIdxOut), w);
            chk("req_lo", 32'(memReadRequest), 0);
            chk("addr_hold", memReadAddress, addr);
        end
        @(negedge clk);
        memDataReady  = 1'b0;
        memBlockIndex = '0;
        memDataIn     = '0;
        #1;
        chk("drain_busy", 32'(busy), 1);
        chk("drain_rdy", 32'({icDataReady, pfDataReady}), 0);
    endtask

    initial begin
        reset         = 1'b0;
        icReadRequest = 1'b0;
        icReadAddress = '0;
        pfReadRequest = 1'b0;
        pfReadAddress = '0;
        memDataIn     = '0;
        memDataReady  = 1'b0;
        memBlockIndex = '0;
        #1;
        chk("rst_outs", 32'({icDataReady, pfDataReady, memReadRequest, grantOwner, busy}), 0);
        chk("rst_addr", memReadAddress, 0);
        @(negedge clk);
        reset = 1'b1;

        // Demand only, burst 3 cycles after the request reaches SDRAM
        @(negedge clk);
        icReadRequest = 1'b1;
        icReadAddress = 32'h0000_0040;
        #1;
        chk("t1_idle", 32'(busy), 0);
        @(negedge clk);
        #1;
        txn(1'b0, 32'h0000_0040, 2, 4, 4, '0);
        icReadRequest = 1'b0;
        @(negedge clk);
        #1;
        chk("t1_done", 32'(busy), 0);

        // Both held continuously, same block: D,D,D,P,D,D,D,P
        icReadRequest = 1'b1;
        icReadAddress = 32'h0000_0100;
        pfReadRequest = 1'b1;
        pfReadAddress = 32'h0000_0104;
        for (int unsigned k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            txn((k % 4) == 3, ((k % 4) == 3) ? 32'h0000_0104 : 32'h0000_0100, k % 3, 4, 4, '0);
            if (k == 7) begin
                icReadRequest = 1'b0;
                pfReadRequest = 1'b0;
            end
            @(negedge clk);
            #1;
            chk("t2_gap", 32'(busy), 0);
        end

        // Demand abandons after first word; prefetch raised while busy is served next
        icReadRequest = 1'b1;
        icReadAddress = 32'h0000_0200;
        @(negedge clk);
        #1;
        pfReadRequest = 1'b1;
        pfReadAddress = 32'h0000_0300;
        txn(1'b0, 32'h0000_0200, 1, 1, 4, '0);
        @(negedge clk);
        #1;
        chk("t3_idle", 32'(busy), 0);
        chk("t3_addr", memReadAddress, 32'h0000_0200);

        // Prefetch owns the channel, demand arrives mid-XFER and waits
        @(negedge clk);
        #1;
        txn(1'b1, 32'h0000_0300, 0, 4, 1, 32'h0000_0400);
        pfReadRequest = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_idle", 32'(busy), 0);
        chk("t5_addr_old", memReadAddress, 32'h0000_0300);
        @(negedge clk);
        #1;
        txn(1'b0, 32'h0000_0400, 0, 4, 4, '0);
        icReadRequest = 1'b0;
        @(negedge clk);
        #1;
        chk("t5_done", 32'(busy), 0);

        // Stray memDataReady while idle
        @(negedge clk);
        memDataReady = 1'b1;
        memDataIn    = 32'hBAD0_0001;
        #1;
        chk("t6_rdy", 32'({icDataReady, pfDataReady}), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_req", 32'(memReadRequest), 0);
        @(negedge clk);
        memDataReady = 1'b0;
        memDataIn    = '0;
        #1;
        chk("t6_stay", 32'(busy), 0);

        // Asynchronous reset during word 2
        @(negedge clk);
        icReadRequest = 1'b1;
        icReadAddress = 32'h0000_0500;
        @(negedge clk);
        #1;
        chk("t4_req", 32'(memReadRequest), 1);
        for (int unsigned w = 0; w < 3; w++) begin
            @(negedge clk);
            memDataReady  = 1'b1;
            memBlockIndex = w[1:0];
            memDataIn     = 32'hCAFE_0000 + w;
        end
        #1;
        chk("t4_w2", 32'(icDataReady), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_rst_outs", 32'({icDataReady, pfDataReady, memReadRequest, grantOwner, busy}), 0);
        chk("t4_rst_data", memDataOut, 0);
        chk("t4_rst_idx", 32'(memBlockIdxOut), 0);
        chk("t4_rst_addr", memReadAddress, 0);
        memDataReady  = 1'b0;
        memBlockIndex = '0;
        memDataIn     = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t4_rel_idle", 32'(busy), 0);
        @(negedge clk);
        #1;
        txn(1'b0, 32'h0000_0500, 0, 4, 4, '0);
        icReadRequest = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_done", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
